// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
// apb_requester_if : command/response stream plus APB4 requester bus bundle
// Revision 1.0
// ============================================================================
interface apb_requester_if #(
  parameter int G_ADDR_WIDTH = 13
);

  // command stream
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [G_ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]             cmd_wdata;
  logic [3:0]              cmd_strb;
  logic [2:0]              cmd_prot;

  // response stream
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  // APB4 requester side
  logic                    m_apb_psel;
  logic                    m_apb_penable;
  logic                    m_apb_pwrite;
  logic [2:0]              m_apb_pprot;
  logic [G_ADDR_WIDTH-1:0] m_apb_paddr;
  logic [31:0]             m_apb_pwdata;
  logic [3:0]              m_apb_pstrb;
  logic                    m_apb_pready;
  logic [31:0]             m_apb_prdata;
  logic                    m_apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot,
    output m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
    input  m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot,
    input  m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
    output m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// apb_requester : valid/ready commands to single APB4 transfers with timeout
// Revision 1.0
// ============================================================================
module apb_requester #(
  parameter int G_ADDR_WIDTH     = 13,
  parameter int G_TIMEOUT_CYCLES = 256
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  apb_requester_if.master bus
);

  localparam bit c_TIMEOUT_EN = (G_TIMEOUT_CYCLES > 0);
  localparam int c_CNT_W      = c_TIMEOUT_EN ? $clog2(G_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    c_TIMEOUT_EN ? c_CNT_W'(G_TIMEOUT_CYCLES - 1) : '0;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  r_state,   w_state;
  logic                    r_cmd_ready, w_cmd_ready;
  logic                    r_psel,    w_psel;
  logic                    r_penable, w_penable;
  logic                    r_pwrite,  w_pwrite;
  logic [2:0]              r_pprot,   w_pprot;
  logic [G_ADDR_WIDTH-1:0] r_paddr,   w_paddr;
  logic [31:0]             r_pwdata,  w_pwdata;
  logic [3:0]              r_pstrb,   w_pstrb;
  logic                    r_rsp_valid, w_rsp_valid;
  logic [31:0]             r_rdata,   w_rdata;
  logic                    r_err,     w_err;
  logic                    r_timeout, w_timeout;
  logic [c_CNT_W-1:0]      r_cnt,     w_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pprot     <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_pprot     <= w_pprot;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_pstrb     <= w_pstrb;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
      r_timeout   <= w_timeout;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_pprot     = r_pprot;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_pstrb     = r_pstrb;
    w_rsp_valid = r_rsp_valid;
    w_rdata     = r_rdata;
    w_err       = r_err;
    w_timeout   = r_timeout;
    w_cnt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_state  = S_SETUP;
          w_psel   = 1'b1;
          w_pwrite = bus.cmd_write;
          w_pprot  = bus.cmd_prot;
          w_paddr  = bus.cmd_addr;
          w_pwdata = bus.cmd_wdata;
          // APB4 forbids active strobes on reads
          w_pstrb  = bus.cmd_write ? bus.cmd_strb : 4'h0;
        end
      end

      S_SETUP: begin
        w_state   = S_ACCESS;
        w_penable = 1'b1;
        w_cnt     = '0;
      end

      S_ACCESS: begin
        if (bus.m_apb_pready) begin
          w_state     = S_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rdata     = r_pwrite ? 32'h0 : bus.m_apb_prdata;
          w_err       = bus.m_apb_pslverr;
          w_timeout   = 1'b0;
        end else if (c_TIMEOUT_EN && (r_cnt == c_CNT_LAST)) begin
          // this wait cycle is the last one allowed; abort without pready
          w_state     = S_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rdata     = 32'h0;
          w_err       = 1'b1;
          w_timeout   = 1'b1;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_valid = 1'b0;
        end
      end

      default: begin
        w_state     = S_IDLE;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase

    w_cmd_ready = (w_state == S_IDLE);
  end

  // cmd_ready is held low while reset is asserted, even in IDLE
  assign bus.cmd_ready     = r_cmd_ready & rst_n;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rdata;
  assign bus.rsp_err       = r_err;
  assign bus.rsp_timeout   = r_timeout;
  assign bus.m_apb_psel    = r_psel;
  assign bus.m_apb_penable = r_penable;
  assign bus.m_apb_pwrite  = r_pwrite;
  assign bus.m_apb_pprot   = r_pprot;
  assign bus.m_apb_paddr   = r_paddr;
  assign bus.m_apb_pwdata  = r_pwdata;
  assign bus.m_apb_pstrb   = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// tb_apb_requester : directed self-checking bench for apb_requester
// Revision 1.0
// ============================================================================
module tb_apb_requester;

  localparam int c_AW = 13;
  localparam int c_TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  apb_requester_if #(.G_ADDR_WIDTH(c_AW)) bus ();

  apb_requester #(
    .G_ADDR_WIDTH    (c_AW),
    .G_TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // observations of the most recent run_cmd
  int              obs_lat, obs_setup_k, obs_pen_first, obs_pen_cnt;
  logic [c_AW-1:0] obs_paddr;
  logic [31:0]     obs_pwdata, obs_rdata;
  logic [3:0]      obs_pstrb;
  logic [2:0]      obs_pprot;
  logic            obs_pwrite, obs_err, obs_to;
  bit              obs_stable, obs_bus_stable, obs_crdy_bad, obs_done, obs_post_ok;

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // response handshake. waits < 0 means the completer never answers.
  task automatic run_cmd(input logic wr, input logic [c_AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input int waits,
                         input logic slverr, input logic [31:0] rdata,
                         input logic early_err, input int hold);
    int rsp_n = 0;
    bit hs    = 0;
    obs_lat = -1; obs_setup_k = -1; obs_pen_first = -1; obs_pen_cnt = 0;
    obs_stable = 1; obs_bus_stable = 1; obs_crdy_bad = 0;
    obs_done = 0; obs_post_ok = 0;
    bus.cmd_valid = 1'b1;  bus.cmd_write = wr;  bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_strb = strb; bus.cmd_prot = prot;
    bus.rsp_ready = 1'b0;  bus.m_apb_pready = 1'b0; bus.m_apb_pslverr = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;  bus.cmd_addr = ~addr;
    bus.cmd_wdata = 32'h0BAD_F00D; bus.cmd_strb = ~strb; bus.cmd_prot = ~prot;
    for (int k = 1; k <= 60 && !obs_done; k++) begin
      if (hs) begin
        obs_post_ok   = !bus.rsp_valid && bus.cmd_ready;
        obs_done      = 1;
        bus.rsp_ready = 1'b0;
      end else begin
        if (bus.cmd_ready) obs_crdy_bad = 1;
        if (bus.m_apb_psel && !bus.m_apb_penable && obs_setup_k < 0) begin
          obs_setup_k = k;
          obs_paddr = bus.m_apb_paddr;   obs_pwdata = bus.m_apb_pwdata;
          obs_pstrb = bus.m_apb_pstrb;   obs_pwrite = bus.m_apb_pwrite;
          obs_pprot = bus.m_apb_pprot;
        end else if (bus.m_apb_psel &&
                     (bus.m_apb_paddr !== obs_paddr || bus.m_apb_pwdata !== obs_pwdata ||
                      bus.m_apb_pstrb !== obs_pstrb || bus.m_apb_pwrite !== obs_pwrite ||
                      bus.m_apb_pprot !== obs_pprot)) begin
          obs_bus_stable = 0;
        end
        bus.m_apb_pready  = 1'b0;
        bus.m_apb_pslverr = 1'b0;
        bus.m_apb_prdata  = 32'hBAD0_BAD0;
        if (bus.m_apb_penable) begin
          obs_pen_cnt++;
          if (obs_pen_first < 0) obs_pen_first = k;
          bus.m_apb_pslverr = early_err;
          if (waits >= 0 && obs_pen_cnt > waits) begin
            bus.m_apb_pready  = 1'b1;
            bus.m_apb_pslverr = slverr;
            bus.m_apb_prdata  = rdata;
          end
        end
        if (bus.rsp_valid) begin
          rsp_n++;
          if (rsp_n == 1) begin
            obs_lat = k; obs_rdata = bus.rsp_rdata;
            obs_err = bus.rsp_err; obs_to = bus.rsp_timeout;
          end else if (bus.rsp_rdata !== obs_rdata || bus.rsp_err !== obs_err ||
                       bus.rsp_timeout !== obs_to) begin
            obs_stable = 0;
          end
          if (rsp_n > hold) begin
            bus.rsp_ready = 1'b1;
            hs = 1;
          end
        end
      end
      if (!obs_done) @(negedge clk);
    end
    bus.m_apb_pready  = 1'b0;
    bus.m_apb_pslverr = 1'b0;
    bus.rsp_ready     = 1'b0;
  endtask

  task automatic check_common(input string tag);
    check({tag, "_done"},      32'(obs_done),       32'd1);
    check({tag, "_post"},      32'(obs_post_ok),    32'd1);
    check({tag, "_crdy_low"},  32'(obs_crdy_bad),   32'd0);
    check({tag, "_bus_stable"},32'(obs_bus_stable), 32'd1);
  endtask

  initial begin
    bit rv_seen = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_strb = '0; bus.cmd_prot = '0; bus.rsp_ready = 0;
    bus.m_apb_pready = 0; bus.m_apb_prdata = '0; bus.m_apb_pslverr = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_psel",      32'(bus.m_apb_psel), 32'd0);
    check("rst_penable",   32'(bus.m_apb_penable), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_buses", {bus.m_apb_pwdata | bus.rsp_rdata | 32'(bus.m_apb_paddr)},
          32'd0);
    check("rst_flags", {25'd0, bus.m_apb_pstrb, bus.rsp_err, bus.rsp_timeout,
          bus.m_apb_pwrite}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // write, zero wait states
    run_cmd(1'b1, 13'h010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0, 0);
    check_common("wr0");
    check("wr0_setup_k",  32'(obs_setup_k),   32'd1);
    check("wr0_pen_first",32'(obs_pen_first), 32'd2);
    check("wr0_paddr",    32'(obs_paddr),     32'h010);
    check("wr0_pwdata",   obs_pwdata,         32'hDEAD_BEEF);
    check("wr0_pstrb",    32'(obs_pstrb),     32'hF);
    check("wr0_pwrite",   32'(obs_pwrite),    32'd1);
    check("wr0_lat",      32'(obs_lat),       32'd3);
    check("wr0_err",      32'(obs_err),       32'd0);
    check("wr0_rdata",    obs_rdata,          32'h0);

    // read, three wait states
    run_cmd(1'b0, 13'h124, 32'h1111_2222, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 1'b0, 0);
    check_common("rd3");
    check("rd3_pstrb",   32'(obs_pstrb),   32'h0);
    check("rd3_pwrite",  32'(obs_pwrite),  32'd0);
    check("rd3_pprot",   32'(obs_pprot),   32'd2);
    check("rd3_pen_cnt", 32'(obs_pen_cnt), 32'd4);
    check("rd3_rdata",   obs_rdata,        32'h1234_5678);
    check("rd3_lat",     32'(obs_lat),     32'd6);

    // slave error, with pslverr also raised during the wait states
    run_cmd(1'b0, 13'h0A0, 32'h0, 4'h0, 3'b001, 2, 1'b1, 32'hCAFE_0001, 1'b1, 0);
    check_common("serr");
    check("serr_err",   32'(obs_err),   32'd1);
    check("serr_to",    32'(obs_to),    32'd0);
    check("serr_rdata", obs_rdata,      32'hCAFE_0001);

    // pslverr while pready=0 must be ignored
    run_cmd(1'b0, 13'h0A4, 32'h0, 4'h0, 3'b000, 2, 1'b0, 32'h0000_55AA, 1'b1, 0);
    check("early_err_ignored", 32'(obs_err), 32'd0);
    check("early_err_rdata",   obs_rdata,    32'h0000_55AA);

    // timeout: pready never arrives
    run_cmd(1'b0, 13'h1F0, 32'h0, 4'hF, 3'b000, -1, 1'b0, 32'h0, 1'b0, 0);
    check_common("tmo");
    check("tmo_pen_cnt", 32'(obs_pen_cnt), 32'd4);
    check("tmo_lat",     32'(obs_lat),     32'd6);
    check("tmo_err",     32'(obs_err),     32'd1);
    check("tmo_to",      32'(obs_to),      32'd1);
    check("tmo_rdata",   obs_rdata,        32'h0);

    // pready on the 4th ACCESS cycle wins over the timeout
    run_cmd(1'b0, 13'h1F4, 32'h0, 4'h0, 3'b000, 3, 1'b0, 32'hA5A5_0F0F, 1'b0, 0);
    check("edge_err",   32'(obs_err), 32'd0);
    check("edge_to",    32'(obs_to),  32'd0);
    check("edge_rdata", obs_rdata,    32'hA5A5_0F0F);

    // back-to-back with response backpressure on the first
    run_cmd(1'b1, 13'h1FFC, 32'h0102_0304, 4'h5, 3'b100, 1, 1'b0, 32'h0, 1'b0, 5);
    check_common("bb1");
    check("bb1_stable", 32'(obs_stable), 32'd1);
    check("bb1_lat",    32'(obs_lat),    32'd4);
    check("bb1_pstrb",  32'(obs_pstrb),  32'h5);
    check("bb1_rdata",  obs_rdata,       32'h0);
    run_cmd(1'b0, 13'h008, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h89AB_CDEF, 1'b0, 0);
    check_common("bb2");
    check("bb2_lat",   32'(obs_lat),   32'd3);
    check("bb2_rdata", obs_rdata,      32'h89AB_CDEF);
    check("bb2_paddr", 32'(obs_paddr), 32'h008);

    // reset for one cycle during ACCESS
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 13'h040;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_in_access", 32'(bus.m_apb_penable), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_psel",      32'(bus.m_apb_psel),    32'd0);
    check("mid_penable",   32'(bus.m_apb_penable), 32'd0);
    check("mid_rsp_valid", 32'(bus.rsp_valid),     32'd0);
    check("mid_cmd_ready", 32'(bus.cmd_ready),     32'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.m_apb_psel) rv_seen = 1;
    end
    bus.rsp_ready = 1'b0;
    check("mid_no_rsp",    32'(rv_seen),       32'd0);
    check("mid_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    run_cmd(1'b1, 13'h044, 32'hFEED_0001, 4'h3, 3'b000, 1, 1'b0, 32'h0, 1'b0, 0);
    check_common("post_rst");
    check("post_rst_pwdata", obs_pwdata,    32'hFEED_0001);
    check("post_rst_lat",    32'(obs_lat),  32'd4);
    check("post_rst_err",    32'(obs_err),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
